branch_cond_unit: RTL and testbench

BRANCH_COND_UNIT -- requirements
Module: branch_cond_unit

---
 rtl/branch_cond_unit.sv | 169 ++++++++++++++++
 tb/tb_branch_cond_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_cond_unit.sv
// branch_cond_unit: evaluates RISC-V conditional branches from ALU compare
// flags (n/z/c/v of a-b). Requests wait for a fresh flag set, then present a
// taken/not-taken result through a valid/ready handshake.
// Optional macro BRANCH_STATS_EN: enables the saturating taken-branch counter
// on taken_cnt; when undefined the counter is absent and taken_cnt reads 0.
module branch_cond_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flag_valid,
  input  logic             n,
  input  logic             z,
  input  logic             c,
  input  logic             v,
  input  logic             br_valid,
  input  logic [2:0]       br_funct3,
  output logic             br_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_taken,
  output logic             res_err,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;     // {N,Z,C,V}
  logic       fresh_q, fresh_d;
  logic [2:0] funct3_q, funct3_d;
  logic       res_taken_q, res_taken_d;
  logic       res_err_q, res_err_d;
  logic       res_valid_q, res_valid_d;
  logic       flags_consumed;
  logic       decision;
  logic       req_illegal;

  // funct3 010 and 011 are the only encodings without a branch meaning
  assign req_illegal = (br_funct3[2:1] == 2'b01);

  // Branch decision from the registered flags and the latched funct3
  always_comb begin
    decision = 1'b0;
    case (funct3_q)
      3'b000:  decision = flags_q[2];                 // beq : Z
      3'b001:  decision = ~flags_q[2];                // bne : ~Z
      3'b100:  decision = flags_q[3] ^ flags_q[0];    // blt : N^V
      3'b101:  decision = ~(flags_q[3] ^ flags_q[0]); // bge : ~(N^V)
      3'b110:  decision = ~flags_q[1];                // bltu: ~C (borrow)
      3'b111:  decision = flags_q[1];                 // bgeu: C
      default: decision = 1'b0;
    endcase
  end

  // Next-state logic for the FSM, flag register and result registers
  always_comb begin
    state_d        = state_q;
    flags_d        = flags_q;
    fresh_d        = fresh_q;
    funct3_d       = funct3_q;
    res_taken_d    = res_taken_q;
    res_err_d      = res_err_q;
    res_valid_d    = res_valid_q;
    flags_consumed = 1'b0;

    case (state_q)
      IDLE: begin
        if (br_valid) begin
          if (req_illegal) begin
            // Illegal request answers immediately and never touches the flags
            res_valid_d = 1'b1;
            res_err_d   = 1'b1;
            res_taken_d = 1'b0;
            state_d     = RESP;
          end else begin
            funct3_d = br_funct3;
            state_d  = WAIT;
          end
        end
      end
      WAIT: begin
        // Stay here (no timeout) until a flag set newer than the last use exists
        if (fresh_q) begin
          flags_consumed = 1'b1;
          res_taken_d    = decision;
          res_err_d      = 1'b0;
          res_valid_d    = 1'b1;
          state_d        = RESP;
        end
      end
      RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        res_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase

    // A flag load in the consuming cycle wins: the decision used the old set,
    // the new set stays marked fresh for the next request.
    if (flag_valid) begin
      flags_d = {n, z, c, v};
      fresh_d = 1'b1;
    end else if (flags_consumed) begin
      fresh_d = 1'b0;
    end
  end

  // State and registered outputs; reset drops any pending request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      flags_q     <= 4'b0000;
      fresh_q     <= 1'b0;
      funct3_q    <= 3'b000;
      res_taken_q <= 1'b0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      flags_q     <= flags_d;
      fresh_q     <= fresh_d;
      funct3_q    <= funct3_d;
      res_taken_q <= res_taken_d;
      res_err_q   <= res_err_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign br_ready  = (state_q == IDLE);
  assign res_valid = res_valid_q;
  assign res_taken = res_taken_q;
  assign res_err   = res_err_q;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count taken results as they are handed off, holding at the maximum
  always_comb begin
    cnt_d = cnt_q;
    if (res_valid_q && res_ready && res_taken_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign taken_cnt = cnt_q;
`else
  assign taken_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_cond_unit.sv
// Testbench for branch_cond_unit: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against an operand-level model
// (decisions come from comparing the a/b operands, not from the flags).
module tb_branch_cond_unit;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flag_valid = 1'b0;
  logic             n = 1'b0, z = 1'b0, c = 1'b0, v = 1'b0;
  logic             br_valid = 1'b0;
  logic [2:0]       br_funct3 = 3'd0;
  logic             br_ready;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic             res_taken;
  logic             res_err;
  logic [CNT_W-1:0] taken_cnt;

  int errors = 0;
  int checks = 0;

  branch_cond_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flag_valid(flag_valid),
    .n(n), .z(z), .c(c), .v(v),
    .br_valid(br_valid), .br_funct3(br_funct3), .br_ready(br_ready),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_taken(res_taken), .res_err(res_err), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (transaction level) ----------------
  logic [31:0] i_a, i_b;          // operands behind the currently driven flags
  bit          m_pend, m_res, m_taken, m_err, m_fresh;
  logic [2:0]  m_f3;
  logic [31:0] m_a, m_b;          // operands of the most recent flag set
  int          m_cnt;

  function automatic bit branch_outcome(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    case (f)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_pend = 0; m_res = 0; m_taken = 0; m_err = 0; m_fresh = 0;
    m_f3 = 3'd0; m_a = 32'd0; m_b = 32'd0; m_cnt = 0;
  endtask

  // Advance the model by one clock using the inputs applied for that edge
  task automatic model_step();
    bit accept, consume;
    accept  = !m_pend && !m_res && br_valid;
    consume = m_pend && m_fresh;
    if (m_res && res_ready) begin
      m_res = 0;
`ifdef BRANCH_STATS_EN
      if (m_taken && m_cnt < CMAX) m_cnt++;
`endif
    end
    if (consume) begin
      m_res = 1; m_err = 0; m_pend = 0;
      m_taken = branch_outcome(m_f3, m_a, m_b);
    end
    if (accept) begin
      if (br_funct3 == 3'd2 || br_funct3 == 3'd3) begin
        m_res = 1; m_err = 1; m_taken = 0;
      end else begin
        m_pend = 1; m_f3 = br_funct3;
      end
    end
    if (flag_valid) begin
      m_fresh = 1; m_a = i_a; m_b = i_b;
    end else if (consume) begin
      m_fresh = 0;
    end
  endtask

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Per-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_br_ready", 32'(br_ready), 32'(!m_pend && !m_res));
      chk("cyc_res_valid", 32'(res_valid), 32'(m_res));
      if (m_res) begin
        chk("cyc_res_taken", 32'(res_taken), 32'(m_taken));
        chk("cyc_res_err", 32'(res_err), 32'(m_err));
      end
      chk("cyc_taken_cnt", 32'(taken_cnt), 32'(m_cnt));
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called just after a rising edge; applies inputs for the next edge.
  task automatic drive(bit fv, logic [31:0] a, logic [31:0] b,
                       bit bv, logic [2:0] f3, bit rr);
    logic [31:0] d;
    d = a - b;
    i_a = a; i_b = b;
    flag_valid = fv;
    n = d[31];
    z = (d == 32'd0);
    c = (a >= b);
    v = (a[31] != b[31]) && (d[31] != a[31]);
    br_valid = bv; br_funct3 = f3; res_ready = rr;
    @(posedge clk);
    model_step();
    #1;
    $display("cyc fv=%0b a=%h b=%h bv=%0b f3=%0d rr=%0d -> rdy=%0b val=%0b tk=%0b err=%0b cnt=%0d",
             fv, a, b, bv, f3, rr, br_ready, res_valid, res_taken, res_err, taken_cnt);
  endtask

  task automatic idle(bit rr);
    drive(0, 32'd0, 32'd0, 0, 3'd0, rr);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_taken", 32'(res_taken), 32'd0);
    chk("rst_res_err", 32'(res_err), 32'd0);
    chk("rst_taken_cnt", 32'(taken_cnt), 32'd0);
    chk("rst_br_ready", 32'(br_ready), 32'd1);
    #1;
    rst_n = 1'b1;
  endtask

  // Load flags from a-b, issue a request, wait (bounded) for the result,
  // check latency and decision literally, then complete the handshake.
  task automatic do_branch(string nm, logic [31:0] a, logic [31:0] b,
                           logic [2:0] f3, bit exp_taken);
    int k;
    drive(1, a, b, 0, 3'd0, 0);
    drive(0, 32'd0, 32'd0, 1, f3, 0);
    k = 1;
    while (!res_valid && k < 10) begin
      idle(0);
      k++;
    end
    chk({nm, "_latency"}, 32'(k), 32'd2);
    chk({nm, "_taken"}, 32'(res_taken), 32'(exp_taken));
    chk({nm, "_err"}, 32'(res_err), 32'd0);
    idle(1);
  endtask

  int exp_cnt[5] = '{1, 2, 3, 3, 3};

  initial begin
    model_reset();
    i_a = 32'd0; i_b = 32'd0;
    #1;
    chk("init_res_valid", 32'(res_valid), 32'd0);
    chk("init_taken_cnt", 32'(taken_cnt), 32'd0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    // 5-5: beq taken with two-cycle latency
    do_branch("beq_5_5", 32'd5, 32'd5, 3'd0, 1'b1);

    // bne with no new flags waits indefinitely
    drive(0, 32'd0, 32'd0, 1, 3'd1, 0);
    for (int i = 0; i < 6; i++) idle(1);
    chk("bne_stall_valid", 32'(res_valid), 32'd0);
    chk("bne_stall_ready", 32'(br_ready), 32'd0);
    drive(1, 32'd5, 32'd6, 0, 3'd0, 0);
    idle(0);
    chk("bne_release_valid", 32'(res_valid), 32'd1);
    chk("bne_release_taken", 32'(res_taken), 32'd1);
    idle(1);

    // 3-7 against signed and unsigned comparisons
    do_branch("blt_3_7", 32'd3, 32'd7, 3'd4, 1'b1);
    do_branch("bltu_3_7", 32'd3, 32'd7, 3'd6, 1'b1);
    do_branch("bgeu_3_7", 32'd3, 32'd7, 3'd7, 1'b0);

    // 0x80000000-1: overflow case
    do_branch("blt_ovf", 32'h8000_0000, 32'd1, 3'd4, 1'b1);
    do_branch("bge_ovf", 32'h8000_0000, 32'd1, 3'd5, 1'b0);

    // Illegal funct3: one-cycle error response, fresh flags kept for later
    drive(1, 32'd9, 32'd9, 0, 3'd0, 0);
    drive(0, 32'd0, 32'd0, 1, 3'd2, 0);
    chk("illegal_valid", 32'(res_valid), 32'd1);
    chk("illegal_err", 32'(res_err), 32'd1);
    chk("illegal_taken", 32'(res_taken), 32'd0);
    idle(1);
    drive(0, 32'd0, 32'd0, 1, 3'd0, 0);
    idle(0);
    chk("after_illegal_valid", 32'(res_valid), 32'd1);
    chk("after_illegal_taken", 32'(res_taken), 32'd1);
    idle(1);

    // Back-pressure: result held, no acceptance while in RESP
    drive(1, 32'd3, 32'd7, 0, 3'd0, 0);
    drive(0, 32'd0, 32'd0, 1, 3'd4, 0);
    idle(0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 32'd0, 32'd0, 1, 3'd0, 0);
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_taken", 32'(res_taken), 32'd1);
      chk("hold_ready", 32'(br_ready), 32'd0);
    end
    drive(0, 32'd0, 32'd0, 1, 3'd0, 1);
    chk("resp_noaccept_ready", 32'(br_ready), 32'd1);
    chk("resp_noaccept_valid", 32'(res_valid), 32'd0);

    // Reset while a request waits in WAIT
    drive(0, 32'd0, 32'd0, 1, 3'd0, 0);
    apply_reset();
    drive(1, 32'd4, 32'd4, 0, 3'd0, 1);
    for (int i = 0; i < 4; i++) idle(1);
    chk("post_rst_valid", 32'(res_valid), 32'd0);

    // Statistics counter saturation
    apply_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      do_branch("cnt_beq", 32'd7, 32'd7, 3'd0, 1'b1);
`ifdef BRANCH_STATS_EN
      chk("taken_cnt_seq", 32'(taken_cnt), 32'(exp_cnt[i]));
`else
      chk("taken_cnt_zero", 32'(taken_cnt), 32'd0);
`endif
    end

    // Randomized traffic
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ra, rb;
      if ($urandom_range(0, 2) == 0) begin
        ra = $urandom_range(0, 3);
        rb = $urandom_range(0, 3);
      end else begin
        ra = $urandom;
        rb = $urandom;
      end
      drive($urandom_range(0, 3) == 0, ra, rb, $urandom_range(0, 1) == 1,
            3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1);
      if (i == 1500) apply_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
